spi_slave_ctrl: RTL

Parametrised SPI slave (mode 0) frame controller: next generation of the fixed 8-bit address/data sequencer. Takes conditioned CS, MOSI and SCLK edge pulses; decodes an address phase (address + R/W bit) then one or more data words. Generates address-latch, data-memory write/read strobes and drives MISO. Adds configurable widths, burst auto-increment, abort detection and true reset.

---
 rtl/spi_slave_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl -- SPI mode-0 slave frame controller.
//
// Decodes a frame of ADDR_W address bits plus one R/W bit, followed by one
// (BURST=0) or a stream of (BURST=1) DATA_W-bit data words, all MSB first.
// Inputs are already synchronised: cs_n, mosi and one-clk SCLK edge pulses.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cs_n                  chip select, active low
//   sclk_pos / sclk_neg   one-clk pulses on SCLK rising / falling edge
//   mosi                  serial data in
//   dm_rdata              memory read data, valid one clk after dm_re
//   addr, addr_we         current word address and its (re)load pulse
//   rw                    1 = read frame, 0 = write frame
//   dm_we, dm_wdata       write strobe and write data
//   dm_re                 read strobe for addr
//   miso, miso_oe         serial data out and its tristate enable
//   busy                  high while a frame is in progress
//   frame_err             pulse when CS rises in the middle of a word
module spi_slave_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter bit BURST  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic              mosi,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_we,
  output logic              rw,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_re,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              frame_err
);

  localparam int MAX_W = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state, state_nx;
  logic              cs_q;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] asr;
  logic [DATA_W-1:0] wsr;
  logic [DATA_W-1:0] rsr;
  logic              re_d;

  logic cs_fall, abort, partial, addr_done, word_end, rd_shift;

  always_comb begin
    cs_fall   = cs_q & ~cs_n;
    // cs_n going high wins over any SCLK pulse in the same clk
    abort     = (state != IDLE) && cs_n;
    partial   = ((state == ADDR) && (cnt != '0)) ||
                ((state == DATA) && (cnt != '0) && (cnt != DATA_END));
    addr_done = (state == ADDR) && !cs_n && sclk_pos && (cnt == ADDR_LAST);
    // cnt parks at DATA_END for one clk so dm_we sees the old address
    // before the burst increment
    word_end  = (state == DATA) && !cs_n && (cnt == DATA_END);
    // at count 0 the MSB is already on miso, so that falling edge is skipped
    rd_shift  = (state == DATA) && !cs_n && rw && sclk_neg &&
                (cnt != '0) && (cnt < DATA_END);

    state_nx = state;
    unique case (state)
      IDLE: if (cs_fall) state_nx = ADDR;
      ADDR: begin
        if (cs_n)           state_nx = IDLE;
        else if (addr_done) state_nx = DATA;
      end
      DATA: begin
        if (cs_n)                   state_nx = IDLE;
        else if (word_end && !BURST) state_nx = DONE;
      end
      DONE: if (cs_n) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q      <= 1'b1;
      cnt       <= '0;
      asr       <= '0;
      wsr       <= '0;
      rsr       <= '0;
      re_d      <= 1'b0;
      addr      <= '0;
      rw        <= 1'b0;
      addr_we   <= 1'b0;
      dm_we     <= 1'b0;
      dm_wdata  <= '0;
      dm_re     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cs_q      <= cs_n;
      addr_we   <= 1'b0;
      dm_we     <= 1'b0;
      dm_re     <= 1'b0;
      frame_err <= 1'b0;
      re_d      <= dm_re;

      // memory answers one clk after dm_re; capture it then
      if (re_d)          rsr <= dm_rdata;
      else if (rd_shift) rsr <= rsr << 1;

      if (abort) begin
        frame_err <= partial;
        cnt       <= '0;
      end else begin
        unique case (state)
          IDLE: cnt <= '0;
          ADDR: begin
            if (sclk_pos) begin
              if (cnt == ADDR_LAST) begin
                addr    <= asr;
                rw      <= mosi;
                addr_we <= 1'b1;
                dm_re   <= mosi;
                cnt     <= '0;
              end else begin
                asr <= ADDR_W'({asr, mosi});
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (word_end) begin
              if (BURST) begin
                addr    <= addr + ADDR_W'(1);
                addr_we <= 1'b1;
                dm_re   <= rw;
                cnt     <= '0;
              end
            end else if (sclk_pos) begin
              wsr <= DATA_W'({wsr, mosi});
              cnt <= cnt + CNT_W'(1);
              if ((cnt == DATA_LAST) && !rw) begin
                dm_wdata <= DATA_W'({wsr, mosi});
                dm_we    <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign miso    = rsr[DATA_W-1];
  assign miso_oe = (state == DATA) && rw;
  assign busy    = (state != IDLE);

endmodule
